// File: rtl/queue_pkg.sv
// Shared sizing for the queue subsystem: default word/pointer widths and depth derivation.
package queue_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    function automatic int queue_depth(input int addr_width);
        return 2 ** addr_width;
    endfunction

    localparam int DEPTH_DEF = queue_depth(ADDR_WIDTH_DEF);
endpackage

// File: rtl/queue_ptr.sv
// Wrapping up-counter used as a FIFO address; rolls DEPTH-1 -> 0 by natural overflow.
module queue_ptr
    import queue_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] ptr
);

    always_ff @(posedge CLK) begin
        if (Reset)
            ptr <= '0;
        else if (en)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/queue_fifo.sv
// Synchronous FIFO storage addressed by two wrapping pointers, with registered
// read data, registered Full/Empty/Count status and one-cycle error pulses.
module queue_fifo
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  WrEn,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  RdEn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Full,
    output logic                  Empty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int DEPTH = queue_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  wr_ok, rd_ok;
    logic [ADDR_WIDTH:0]   count_nxt;

    assign wr_ok = WrEn & ~Full;
    assign rd_ok = RdEn & ~Empty;

    queue_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (wr_ok),
        .ptr   (wr_ptr)
    );

    queue_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (rd_ok),
        .ptr   (rd_ptr)
    );

    // Storage is never cleared; a write coincident with reset is dropped.
    always_ff @(posedge CLK) begin
        if (!Reset && wr_ok)
            mem[wr_ptr] <= DataIn;
    end

    always_comb begin
        count_nxt = Count;
        if (wr_ok && !rd_ok)
            count_nxt = Count + 1'b1;
        else if (rd_ok && !wr_ok)
            count_nxt = Count - 1'b1;
    end

    // Flags are derived from the next count so they track Count on the same edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Count     <= '0;
            Full      <= 1'b0;
            Empty     <= 1'b1;
            DataOut   <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Count     <= count_nxt;
            Full      <= (count_nxt == COUNT_FULL);
            Empty     <= (count_nxt == '0);
            Overflow  <= WrEn & Full;
            Underflow <= RdEn & Empty;
            if (rd_ok)
                DataOut <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_queue_fifo.sv
// Directed bench for queue_fifo at default sizing (8-bit words, 16 entries).
module tb_queue_fifo;
    logic       CLK = 1'b0;
    logic       Reset, WrEn, RdEn;
    logic [7:0] DataIn, DataOut;
    logic       Full, Empty, Overflow, Underflow;
    logic [4:0] Count;

    int n_checks = 0;
    int n_fail   = 0;

    queue_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .WrEn      (WrEn),
        .DataIn    (DataIn),
        .RdEn      (RdEn),
        .DataOut   (DataOut),
        .Full      (Full),
        .Empty     (Empty),
        .Count     (Count),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic wr, input logic rd, input logic [7:0] din);
        Reset  = rst;
        WrEn   = wr;
        RdEn   = rd;
        DataIn = din;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        WrEn  = 1'b0;
        RdEn  = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int cnt, input logic f, input logic e,
                              input logic ov, input logic un);
        chk({tag, ".count"}, 32'(Count), 32'(cnt));
        chk({tag, ".full"}, 32'(Full), 32'(f));
        chk({tag, ".empty"}, 32'(Empty), 32'(e));
        chk({tag, ".ovf"}, 32'(Overflow), 32'(ov));
        chk({tag, ".unf"}, 32'(Underflow), 32'(un));
    endtask

    initial begin
        Reset = 1'b0; WrEn = 1'b0; RdEn = 1'b0; DataIn = '0;
        @(negedge CLK);

        // 1: reset wins over simultaneous requests
        cyc(1'b1, 1'b1, 1'b1, 8'hC3);
        chk_status("reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset.dout", 32'(DataOut), 32'h00);

        // 2: fill 0x01..0x10, then a rejected write
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'(i));
            chk("fill.count", 32'(Count), 32'(i));
        end
        chk_status("full", 16, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        chk_status("ovf", 16, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf.clear", 32'(Overflow), 32'h0);

        // 3: drain in order, then a rejected read
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain.dout", 32'(DataOut), 32'(i));
            chk("drain.count", 32'(Count), 32'(16 - i));
        end
        chk_status("empty", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk_status("unf", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("unf.dout", 32'(DataOut), 32'h10);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("unf.clear", 32'(Underflow), 32'h0);

        // 4: streaming through wrap-around with a 3-deep backlog
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
        chk("stream.fill", 32'(Count), 32'd3);
        for (int i = 3; i < 40; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'(i));
            chk("stream.dout", 32'(DataOut), 32'(i - 3));
            chk("stream.count", 32'(Count), 32'd3);
        end
        for (int i = 37; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("stream.tail", 32'(DataOut), 32'(i));
        end
        chk("stream.empty", 32'(Empty), 32'h1);

        // 5a: simultaneous requests while empty
        cyc(1'b0, 1'b1, 1'b1, 8'h77);
        chk_status("sim_empty", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sim_empty.dout", 32'(DataOut), 32'h27);

        // 5b: simultaneous requests while full
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        chk("sim_full.pre", 32'(Full), 32'h1);
        cyc(1'b0, 1'b1, 1'b1, 8'h99);
        chk_status("sim_full", 15, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sim_full.dout", 32'(DataOut), 32'h77);

        // 6: reset mid-stream discards buffered data
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        chk("mid.count", 32'(Count), 32'd5);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        chk_status("mid_rst", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_rst.dout", 32'(DataOut), 32'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h55);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_rst.dout", 32'(DataOut), 32'h55);
        chk("post_rst.empty", 32'(Empty), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/queue_fifo.md
Name: queue_fifo

Overview:
- Synchronous FIFO queue storage that consumes up-counter pointer values as write/read addresses.
- Buffers DATA_WIDTH-bit words between a producer and a consumer.
- Provides Full/Empty/Count status and one-cycle overflow/underflow error pulses.
- Sits directly downstream of the queue pointer counters in the Queue subsystem.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH (default 16 entries).

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
- WrEn  input  1  write request.
- DataIn  input  DATA_WIDTH  write data, sampled when a write is accepted.
- RdEn  input  1  read request.
- DataOut  output  DATA_WIDTH  read data, registered.
- Full  output  1  high when Count == DEPTH.
- Empty  output  1  high when Count == 0.
- Count  output  ADDR_WIDTH+1  number of stored words, range 0..DEPTH.
- Overflow  output  1  one-cycle pulse on a rejected write.
- Underflow  output  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset (Reset=1 at a rising edge):
  - WrPtr=0, RdPtr=0, Count=0, Empty=1, Full=0, DataOut=0, Overflow=0, Underflow=0.
  - Memory contents are not cleared.
  - Reset takes priority over any simultaneous WrEn or RdEn.
- Write acceptance: wr_ok = WrEn & ~Full. On wr_ok:
  - mem[WrPtr] <= DataIn.
  - WrPtr <= WrPtr+1, modulo DEPTH.
- Read acceptance: rd_ok = RdEn & ~Empty. On rd_ok:
  - DataOut <= mem[RdPtr], visible the cycle after the request (latency 1).
  - RdPtr <= RdPtr+1, modulo DEPTH.
- DataOut holds its last value whenever no read is accepted.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged on both or neither.
- Full and Empty are registered and updated on the same edge as Count, so they reflect the post-edge Count.
- Simultaneous requests:
  - Neither full nor empty: both accepted; Count unchanged.
  - Full: read accepted, write rejected (Overflow=1); Count becomes DEPTH-1.
  - Empty: write accepted, read rejected (Underflow=1). There is no bypass; DataOut is unchanged and Count becomes 1.
- Error pulses:
  - Overflow <= WrEn & Full.
  - Underflow <= RdEn & Empty.
  - Each is high for exactly one cycle per rejected request and is not sticky.
  - Rejected requests change no other state.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no discontinuity in data order.
- Reset mid-operation: all buffered data is discarded; the next read after reset sees Empty=1.
- Pointer width rules: pointers are ADDR_WIDTH bits; Count is ADDR_WIDTH+1 bits so that full and empty are distinguishable.
- State: registered datapath only, no separate FSM. Implied status states are EMPTY, PARTIAL and FULL:
  - EMPTY -> PARTIAL on write.
  - PARTIAL -> FULL when Count reaches DEPTH.
  - FULL -> PARTIAL on read.
  - PARTIAL -> EMPTY when Count reaches 0.

Decomposition:
- Shared package queue_pkg holds:
  - DATA_WIDTH_DEF = 8 and ADDR_WIDTH_DEF = 4.
  - The DEPTH derivation.
- One natural sub-module: queue_ptr, an ADDR_WIDTH-bit wrapping pointer register with synchronous Reset and an increment enable.
  - Two instances: write pointer (enable = wr_ok) and read pointer (enable = rd_ok).
- Memory array, count register and flag logic stay in queue_fifo.

Test Plan (defaults: DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=16):
1. Assert Reset for one edge with WrEn=RdEn=1 -> after the edge Count=0, Empty=1, Full=0, DataOut=0x00, Overflow=Underflow=0.
2. Write 0x01..0x10 on 16 consecutive cycles, then attempt write 0xAA -> Full=1 and Count=16 after the 16th edge; Overflow pulses for one cycle; 0xAA is never read back.
3. From full, read 16 times -> DataOut = 0x01..0x10 in order, each valid one cycle after its RdEn; Empty=1 after the last edge; a 17th RdEn gives a one-cycle Underflow pulse and DataOut stays 0x10.
4. Stream 40 words 0x00..0x27, writing every cycle and reading every cycle after an initial 3-word fill -> pointers wrap twice, Count stays at 3, DataOut order is exactly 0x00..0x27 with no loss.
5. Simultaneous WrEn=RdEn=1:
   - When Empty -> Count=1, Underflow=1, DataOut unchanged.
   - When Full -> Count=15, Overflow=1, DataOut = the oldest word.
6. Write 5 words, assert Reset mid-stream with RdEn high -> Count=0 and Empty=1 after the edge; a following write of 0x55 then read returns 0x55.
